// File: rtl/pipe_if_fetch.sv
// pipe_if_fetch: instruction-fetch front end.
// Owns the PC, issues one word fetch at a time over a req/ack handshake,
// buffers returned words in a DEPTH-entry FIFO and hands them to decode.
// Redirects (branch / jr / jump) coming back from decode flush the FIFO and
// squash any fetch still in flight.
// Optional feature: define IF_BYPASS_EN to forward an acked word straight to
// decode when the FIFO is empty (zero-cycle fetch latency).
module pipe_if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        resetn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ds_valid,
    input  logic        ds_ready,
    output logic [31:0] ds_inst,
    output logic [31:0] ds_pc4,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc
);

    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = (DEPTH > 3) ? 3 : 2;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [31:0]      pc_reg, pc_next;
    logic [31:0]      addr_reg, addr_next;
    logic             busy_reg, busy_next;
    logic             drop_reg, drop_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;

    logic [31:0] inst_mem [DEPTH];
    logic [31:0] pc4_mem  [DEPTH];

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        fifo_valid;
    logic        bypass_hit;
    logic        redirect;
    logic        req_start;
    logic        ack_take;
    logic        push;
    logic        pop;

    assign pc_plus4   = pc_reg + 32'd4;
    assign fifo_valid = (count_reg != '0);

`ifdef IF_BYPASS_EN
    // An acked word may go straight to decode only when nothing older is
    // queued and the response is not one we are about to throw away.
    assign bypass_hit = resetn & ~fifo_valid & ~drop_reg & imem_ack;
`else
    assign bypass_hit = 1'b0;
`endif

    assign ds_valid = fifo_valid | bypass_hit;
    assign ds_inst  = fifo_valid ? inst_mem[rd_ptr_reg] :
                      (bypass_hit ? imem_rdata : 32'd0);
    assign ds_pc4   = fifo_valid ? pc4_mem[rd_ptr_reg] :
                      (bypass_hit ? pc_plus4 : 32'd0);

    // A taken control transfer squashes every younger fetch (no delay slot).
    assign redirect = ds_valid & ds_ready & (pcsource != 2'b00);

    // A new fetch is not started in a redirect cycle: the PC is about to
    // change, and starting one here would only have to be dropped later.
    // Occupancy is the registered count, so a full FIFO re-requests only
    // the cycle after its first dequeue.
    assign req_start = resetn & ~busy_reg & (count_reg < FULL_CNT) & ~redirect;
    assign imem_req  = (resetn & busy_reg) | req_start;
    // While a fetch is outstanding the PC may already hold a redirect
    // target, so the address comes from the latched request address.
    assign imem_addr = busy_reg ? addr_reg : pc_reg;

    assign ack_take = imem_ack & imem_req;
    assign push     = ack_take & ~drop_reg & ~redirect & ~(bypass_hit & ds_ready);
    assign pop      = fifo_valid & ds_ready;

    // Redirect target selection from the control unit's pcsource.
    always_comb begin
        target = pc_plus4;
        case (pcsource)
            2'b01:   target = bpc;
            2'b10:   target = rpc;
            2'b11:   target = jpc;
            default: target = pc_plus4;
        endcase
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Next-state logic for PC, handshake tracking and FIFO bookkeeping.
    always_comb begin
        pc_next     = pc_reg;
        addr_next   = addr_reg;
        busy_next   = busy_reg;
        drop_next   = drop_reg;
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;

        if (req_start && !imem_ack) begin
            busy_next = 1'b1;
            addr_next = pc_reg;
        end
        if (ack_take) begin
            busy_next = 1'b0;
            drop_next = 1'b0;
            // A dropped response leaves the PC alone: it already holds the
            // redirect target.
            if (!drop_reg) begin
                pc_next = pc_plus4;
            end
        end

        if (redirect) begin
            pc_next     = target;
            count_next  = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            // Same-cycle ack data is simply not enqueued; a later ack must
            // be remembered and discarded.
            if (busy_reg && !imem_ack) begin
                drop_next = 1'b1;
            end
        end else begin
            count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wr_ptr_next = ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_next = ptr_inc(rd_ptr_reg);
            end
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc_reg     <= RESET_PC;
            addr_reg   <= RESET_PC;
            busy_reg   <= 1'b0;
            drop_reg   <= 1'b0;
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            pc_reg     <= pc_next;
            addr_reg   <= addr_next;
            busy_reg   <= busy_next;
            drop_reg   <= drop_next;
            count_reg  <= count_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
        end
    end

    // FIFO storage; contents need no reset because count gates visibility.
    always_ff @(posedge clock) begin
        if (push) begin
            inst_mem[wr_ptr_reg] <= imem_rdata;
            pc4_mem[wr_ptr_reg]  <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_pipe_if_fetch.sv
// tb_pipe_if_fetch: directed scenarios plus a randomized run checked against
// a program-order reference model (expected PC stream driven by pcsource).
module tb_pipe_if_fetch;

`ifdef IF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clock;
    logic        resetn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ds_valid;
    logic        ds_ready;
    logic [31:0] ds_inst;
    logic [31:0] ds_pc4;
    logic [1:0]  pcsource;
    logic [31:0] bpc, rpc, jpc;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_if_fetch #(
        .RESET_PC (32'h0000_0100),
        .DEPTH    (2)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ds_valid   (ds_valid),
        .ds_ready   (ds_ready),
        .ds_inst    (ds_inst),
        .ds_pc4     (ds_pc4),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .rpc        (rpc),
        .jpc        (jpc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5EED_1234;
    endfunction

    function automatic logic [31:0] rand_target();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
        return 32'($urandom_range(0, 1023)) << 2;
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
        imem_ack = 1'b0;
        pcsource = 2'b00;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        resetn   = 1'b0;
        imem_ack = 1'b0;
        ds_ready = 1'b0;
        pcsource = 2'b00;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          acks;
        logic [31:0] exp_pc;
        logic        pend;
        logic [31:0] pend_addr;
        int          wait_left;
        logic        held;
        logic [31:0] held_inst, held_pc4;
        int          accepted;
        int          r;

        resetn = 1'b0; imem_ack = 1'b0; imem_rdata = '0; ds_ready = 1'b0;
        pcsource = 2'b00; bpc = '0; rpc = '0; jpc = '0;

        // Reset values, then first post-reset request.
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_req",   imem_req,  32'd0);
        check_val("rst_addr",  imem_addr, 32'h100);
        check_val("rst_valid", ds_valid,  32'd0);
        check_val("rst_inst",  ds_inst,   32'd0);
        check_val("rst_pc4",   ds_pc4,    32'd0);
        resetn = 1'b1;
        #1;
        check_val("first_req",  imem_req,  32'd1);
        check_val("first_addr", imem_addr, 32'h100);
        $display("txn reset: req=%0b addr=%08h", imem_req, imem_addr);

        // Zero-wait stream with decode always ready.
        ds_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic exp_v;
            if (k > 0) next_cycle();
            #1;
            check_val("stream_req",  imem_req,  32'd1);
            check_val("stream_addr", imem_addr, 32'h100 + 32'(4 * k));
            imem_ack   = 1'b1;
            imem_rdata = imem_addr;
            #1;
            exp_v = (k >= 1) || BYPASS;
            check_val("stream_valid", ds_valid, 32'(exp_v));
            if (exp_v) begin
                check_val("stream_pc4",  ds_pc4,  32'h100 + 32'(4 * k) + (BYPASS ? 32'd4 : 32'd0));
                check_val("stream_inst", ds_inst, ds_pc4 - 32'd4);
            end
            $display("txn stream %0d: addr=%08h valid=%0b pc4=%08h", k, imem_addr, ds_valid, ds_pc4);
        end

        // Stall with DEPTH=2: exactly two acks, then request drops.
        do_reset();
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) next_cycle();
            #1;
            if (imem_req) begin
                acks++;
                imem_ack   = 1'b1;
                imem_rdata = imem_addr;
            end
            #1;
        end
        check_val("full_acks", 32'(acks), 32'd2);
        check_val("full_req",  imem_req,  32'd0);
        next_cycle();
        ds_ready = 1'b1;
        #1;
        check_val("full_deq_req", imem_req, 32'd0);
        check_val("full_deq_pc4", ds_pc4,   32'h104);
        next_cycle();
        ds_ready = 1'b0;
        #1;
        check_val("full_resume_req",  imem_req,  32'd1);
        check_val("full_resume_addr", imem_addr, 32'h108);
        $display("txn full: acks=%0d resume addr=%08h", acks, imem_addr);

        // Jump while a slow fetch is outstanding: response dropped.
        do_reset();
        #1;
        imem_ack = 1'b1; imem_rdata = 32'h100;
        next_cycle();
        #1;
        check_val("drop_c1_addr", imem_addr, 32'h104);
        next_cycle();
        ds_ready = 1'b1; pcsource = 2'b11; jpc = 32'h400;
        #1;
        check_val("drop_c2_req",  imem_req,  32'd1);
        check_val("drop_c2_addr", imem_addr, 32'h104);
        next_cycle();
        ds_ready = 1'b0;
        #1;
        check_val("drop_c3_addr",  imem_addr, 32'h104);
        check_val("drop_c3_valid", ds_valid,  32'd0);
        next_cycle();
        #1;
        check_val("drop_c4_req",  imem_req,  32'd1);
        check_val("drop_c4_addr", imem_addr, 32'h104);
        imem_ack = 1'b1; imem_rdata = 32'h104;
        #1;
        check_val("drop_c4_valid", ds_valid, 32'd0);
        next_cycle();
        #1;
        check_val("drop_c5_req",  imem_req,  32'd1);
        check_val("drop_c5_addr", imem_addr, 32'h400);
        imem_ack = 1'b1; imem_rdata = 32'h400;
        #1;
        check_val("drop_c5_valid", ds_valid, 32'(BYPASS));
        next_cycle();
        #1;
        check_val("drop_c6_valid", ds_valid, 32'd1);
        check_val("drop_c6_pc4",   ds_pc4,   32'h404);
        check_val("drop_c6_inst",  ds_inst,  32'h400);
        $display("txn jump-drop: pc4=%08h inst=%08h", ds_pc4, ds_inst);

        // Branch in the same cycle as an ack: that word never appears.
        do_reset();
        #1;
        imem_ack = 1'b1; imem_rdata = 32'h100;
        next_cycle();
        next_cycle();
        ds_ready = 1'b1; pcsource = 2'b01; bpc = 32'h200;
        #1;
        check_val("br_ack_addr", imem_addr, 32'h104);
        imem_ack = 1'b1; imem_rdata = 32'h104;
        #1;
        next_cycle();
        ds_ready = 1'b0;
        #1;
        check_val("br_next_req",   imem_req,  32'd1);
        check_val("br_next_addr",  imem_addr, 32'h200);
        check_val("br_next_valid", ds_valid,  32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h200;
        #1;
        check_val("br_tgt_valid", ds_valid, 32'(BYPASS));
        next_cycle();
        #1;
        check_val("br_out_valid", ds_valid, 32'd1);
        check_val("br_out_pc4",   ds_pc4,   32'h204);
        check_val("br_out_inst",  ds_inst,  32'h200);
        $display("txn branch-ack: pc4=%08h inst=%08h", ds_pc4, ds_inst);

        // PC wrap at the top of the address space.
        do_reset();
        #1;
        imem_ack = 1'b1; imem_rdata = 32'h100;
        next_cycle();
        ds_ready = 1'b1; pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
        #1;
        next_cycle();
        ds_ready = 1'b0;
        #1;
        check_val("wrap_req",  imem_req,  32'd1);
        check_val("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        #1;
        check_val("wrap_ack_valid", ds_valid, 32'(BYPASS));
`ifdef IF_BYPASS_EN
        check_val("wrap_bypass_pc4", ds_pc4, 32'd0);
`endif
        next_cycle();
        #1;
        check_val("wrap_valid",     ds_valid,  32'd1);
        check_val("wrap_pc4",       ds_pc4,    32'd0);
        check_val("wrap_inst",      ds_inst,   32'h1234_5678);
        check_val("wrap_next_req",  imem_req,  32'd1);
        check_val("wrap_next_addr", imem_addr, 32'd0);
        $display("txn wrap: pc4=%08h next addr=%08h", ds_pc4, imem_addr);

        // Reset asserted while a request is outstanding.
        do_reset();
        next_cycle();
        #1;
        check_val("arst_pre_req", imem_req, 32'd1);
        resetn = 1'b0;
        #1;
        check_val("arst_req",  imem_req,  32'd0);
        check_val("arst_addr", imem_addr, 32'h100);
        $display("txn async-reset: req=%0b", imem_req);

        // Randomized run: delivered stream must follow program order.
        do_reset();
        exp_pc = 32'h100; pend = 1'b0; pend_addr = '0; wait_left = 0;
        held = 1'b0; held_inst = '0; held_pc4 = '0; accepted = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            ds_ready   = ($urandom_range(0, 3) != 0);
            r          = $urandom_range(0, 9);
            pcsource   = (r < 7) ? 2'b00 : 2'(r - 6);
            bpc = rand_target(); rpc = rand_target(); jpc = rand_target();
            #1;
            if (pend) begin
                check_val("rnd_req_hold",  imem_req,  32'd1);
                check_val("rnd_addr_hold", imem_addr, pend_addr);
            end
            if (imem_req) begin
                if (!pend) begin
                    pend      = 1'b1;
                    pend_addr = imem_addr;
                    wait_left = $urandom_range(0, 3);
                end
                if (wait_left == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                end else begin
                    wait_left--;
                end
            end
            #3;
            if (held) begin
                check_val("rnd_stall_valid", ds_valid, 32'd1);
                check_val("rnd_stall_inst",  ds_inst,  held_inst);
                check_val("rnd_stall_pc4",   ds_pc4,   held_pc4);
            end
            if (ds_valid && ds_ready) begin
                check_val("rnd_inst", ds_inst, mem_word(exp_pc));
                check_val("rnd_pc4",  ds_pc4,  exp_pc + 32'd4);
                $display("txn rnd %0d: pc=%08h inst=%08h src=%0d", accepted, exp_pc, ds_inst, pcsource);
                accepted++;
                case (pcsource)
                    2'b01:   exp_pc = bpc;
                    2'b10:   exp_pc = rpc;
                    2'b11:   exp_pc = jpc;
                    default: exp_pc = exp_pc + 32'd4;
                endcase
            end
            held      = ds_valid && !ds_ready;
            held_inst = ds_inst;
            held_pc4  = ds_pc4;
            @(posedge clock);
            if (imem_ack) pend = 1'b0;
            #1;
        end
        check_val("rnd_progress", 32'(accepted > 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_if_fetch.md
# pipe_if_fetch

Instruction-fetch front end for the pipelined computer. It owns the program counter, issues word fetches to instruction memory over a req/ack handshake, and buffers fetched words in a small FIFO. It presents the words to the decode stage, where the control unit turns op/func into control signals. It closes the loop by consuming the `pcsource` selection and branch/jump targets coming back from decode.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset.
- `DEPTH`, default 2: instruction-buffer entries; 2..4 supported.

- `clock`  in  1  single clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  word address of the fetch (the PC); bits [1:0] always 0.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle; accepted on the edge.
- `imem_rdata`  in  32  instruction word; valid only when `imem_ack`=1.
- `ds_valid`  out  1  `ds_inst` / `ds_pc4` hold a valid instruction.
- `ds_ready`  in  1  decode accepts the instruction this cycle (0 = pipeline stall).
- `ds_inst`  out  32  instruction word to decode.
- `ds_pc4`  out  32  address of `ds_inst` plus 4.
- `pcsource`  in  2  next-PC select from the control unit for the instruction being accepted:
  - 00: sequential
  - 01: branch target `bpc`
  - 10: register target `rpc` (jr)
  - 11: jump target `jpc` (j/jal)
- `bpc`, `rpc`, `jpc`  in  32 each  redirect targets.

## Operation
- Architectural state:
  - `pc`
  - FIFO of {inst, pc4} entries, with `count` 0..DEPTH
  - `busy`: request outstanding
  - `drop`: discard the outstanding response
- Request rules:
  - `imem_req` rises when `busy`=0 and `count`<DEPTH.
  - Once raised, `imem_req` and `imem_addr` hold stable through the ack cycle inclusive.
  - Ack may arrive in the same cycle as req or any later cycle.
  - At most one request is outstanding.
- On ack with `drop`=0: enqueue {`imem_rdata`, `pc`+4}, then `pc` <= `pc`+4. A new request may start the following cycle.
- On ack with `drop`=1: discard the data, clear `drop`, leave `pc` unchanged (it already holds the redirect target).
- Dequeue: the head entry drives `ds_inst` and `ds_pc4`. An entry retires when `ds_valid` & `ds_ready`.
- Redirect condition: `ds_valid` & `ds_ready` & (`pcsource`!=00). On redirect:
  - Flush all remaining FIFO entries, so `count`=0 next cycle.
  - `pc` <= selected target.
  - If a request is outstanding and its ack is not this cycle, set `drop`.
  - If the ack is in this same cycle, discard that ack data and do not set `drop`.
- No branch delay slot: every instruction younger than the redirecting one is squashed.
- Enqueue and dequeue in the same cycle are allowed at any `count`, including full.
- Arithmetic: `pc`+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Reset (asynchronous): `pc`=`RESET_PC`, `count`=0, `busy`=0, `drop`=0.

## Timing
- Reset values:
  - `imem_req`=0
  - `imem_addr`=`RESET_PC`
  - `ds_valid`=0
  - `ds_inst`=0
  - `ds_pc4`=0
- First cycle after `resetn` deasserts: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Fetch latency without bypass: ack in cycle N gives `ds_valid`=1 in cycle N+1.
- Throughput: one instruction per cycle with zero-wait ack and `ds_ready`=1.
- Redirect in cycle N with no outstanding request: `imem_addr` = target with `imem_req`=1 in N+1.
- Redirect with an outstanding request: the target request starts the cycle after the dropped ack. `ds_valid` stays 0 until the target's data is returned.
- Full FIFO (`count`=DEPTH) with no dequeue: `imem_req` stays 0 until the first dequeue edge, then rises next cycle.
- Reset asserted mid-request: the request is abandoned immediately, with `imem_req`=0 asynchronously.

## Configuration
- `IF_BYPASS_EN`:
  - Defined: when `count`=0, `drop`=0 and `imem_ack`=1, `ds_valid`=1 combinationally with `ds_inst`=`imem_rdata` and `ds_pc4`=`pc`+4. If `ds_ready`=1 the word is consumed without being enqueued; otherwise it is enqueued normally. Fetch latency drops to 0 cycles.
  - Undefined: all words pass through the FIFO, with 1-cycle latency.

## Test plan
- Reset with `RESET_PC`=32'h0000_0100 -> outputs at reset values. First post-reset cycle: `imem_req`=1, `imem_addr`=0x100.
- Zero-wait ack stream with `ds_ready`=1, rdata = address -> `ds_pc4` sequence 0x104, 0x108, ... every cycle (no bypass: first valid one cycle after the first ack).
- Hold `ds_ready`=0 with DEPTH=2 -> exactly 2 acks accepted and `imem_req`=0. Raise `ds_ready` -> `imem_req` returns the next cycle with addr 0x108.
- Ack delayed 3 cycles; redirect `pcsource`=11, `jpc`=0x400 while busy -> the old data is dropped, the next request goes to 0x400, and the first `ds_pc4` after is 0x404.
- Redirect (`pcsource`=01, `bpc`=0x200) in the same cycle as an ack -> the acked word never appears; the next `imem_addr`=0x200; `drop` remains 0.
- `pc`=0xFFFF_FFFC fetch -> `ds_pc4`=0, next `imem_addr`=0. With `IF_BYPASS_EN`, an empty FIFO plus ack -> `ds_valid`=1 in the same cycle.
